soc_system_pio_edge_irq: RTL and testbench

//  Parametrised Avalon-MM input PIO with per-bit edge capture and interrupt; successor to the

---
 rtl/soc_system_pio_edge_irq.sv | 164 ++++++++++++++++
 tb/tb_soc_system_pio_edge_irq.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/soc_system_pio_edge_irq.sv
// soc_system_pio_edge_irq
//   WIDTH-channel Avalon-MM input PIO for the HPS lightweight bridge.
//   Each channel passes through a SYNC_STAGES-deep synchroniser. It then feeds an
//   optional debounce filter. Rising and falling edges of the filtered value are
//   captured per bit in EDGE_CAP, which is cleared by writing 1. irq is the OR of
//   the captured bits that are unmasked.
//   Optional feature macro: PIO_DEBOUNCE_EN. When defined, it adds per-channel
//   debounce counters and the DBNC_LIMIT register at address 5. When undefined,
//   the filtered value follows the synchroniser every clock, and address 5 reads 0.
module soc_system_pio_edge_irq #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DBNC_W      = 16,
    parameter int DBNC_RST    = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [2:0] ADDR_DATA  = 3'd0;
    localparam logic [2:0] ADDR_RISE  = 3'd1;
    localparam logic [2:0] ADDR_MASK  = 3'd2;
    localparam logic [2:0] ADDR_EDGE  = 3'd3;
    localparam logic [2:0] ADDR_FALL  = 3'd4;
    localparam logic [2:0] ADDR_LIMIT = 3'd5;

    logic             wr_en;
    logic [WIDTH-1:0] wdata_w;
    logic [WIDTH-1:0] sync_chain [SYNC_STAGES];
    logic [WIDTH-1:0] sync_val;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] rise_en;
    logic [WIDTH-1:0] fall_en;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] cap_set;
    logic [WIDTH-1:0] cap_clr;
    logic [31:0]      rd_mux;
    logic             unused_wdata;

    assign wr_en    = chipselect & ~write_n;
    assign wdata_w  = writedata[WIDTH-1:0];
    assign sync_val = sync_chain[SYNC_STAGES-1];

    // Upper writedata bits are don't-care for narrow configurations
    assign unused_wdata = ^writedata;

    // Metastability synchroniser for the asynchronous board inputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_chain[s] <= '0;
        end else begin
            sync_chain[0] <= in_port;
            for (int s = 1; s < SYNC_STAGES; s++) sync_chain[s] <= sync_chain[s-1];
        end
    end

`ifdef PIO_DEBOUNCE_EN
    logic [DBNC_W-1:0] dbnc_limit;
    logic [DBNC_W-1:0] cnt [WIDTH];

    // Debounce limit register; a rewrite applies to counters already running
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dbnc_limit <= DBNC_W'(DBNC_RST);
        end else if (wr_en && (address == ADDR_LIMIT)) begin
            dbnc_limit <= writedata[DBNC_W-1:0];
        end
    end

    // Per-bit debounce: a change must persist limit+1 consecutive cycles to be accepted
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable <= '0;
            for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync_val[i] != stable[i]) begin
                    // >= lets a lowered limit release a counter that is already past it
                    if (cnt[i] >= dbnc_limit) begin
                        stable[i] <= sync_val[i];
                        cnt[i]    <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + DBNC_W'(1);
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end
`else
    localparam bit unused_cfg = (DBNC_W != DBNC_RST);

    // Without debounce the filtered value tracks the synchroniser directly
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable <= '0;
        end else begin
            stable <= sync_val;
        end
    end
`endif

    assign rise    = stable & ~stable_d;
    assign fall    = ~stable & stable_d;
    assign cap_set = (rise & rise_en) | (fall & fall_en);
    assign cap_clr = (wr_en && (address == ADDR_EDGE)) ? wdata_w : '0;

    // Control registers and edge capture; a new edge beats a same-cycle W1C clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_d <= '0;
            rise_en  <= '0;
            fall_en  <= '1;
            irq_mask <= '0;
            edge_cap <= '0;
        end else begin
            stable_d <= stable;
            if (wr_en && (address == ADDR_RISE)) rise_en  <= wdata_w;
            if (wr_en && (address == ADDR_FALL)) fall_en  <= wdata_w;
            if (wr_en && (address == ADDR_MASK)) irq_mask <= wdata_w;
            edge_cap <= (edge_cap & ~cap_clr) | cap_set;
        end
    end

    assign irq = |(edge_cap & irq_mask);

    // Read mux: zero-extended register selected by address, unmapped reads 0
    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA:  rd_mux[WIDTH-1:0] = stable;
            ADDR_RISE:  rd_mux[WIDTH-1:0] = rise_en;
            ADDR_MASK:  rd_mux[WIDTH-1:0] = irq_mask;
            ADDR_EDGE:  rd_mux[WIDTH-1:0] = edge_cap;
            ADDR_FALL:  rd_mux[WIDTH-1:0] = fall_en;
`ifdef PIO_DEBOUNCE_EN
            ADDR_LIMIT: rd_mux[DBNC_W-1:0] = dbnc_limit;
`endif
            default:    rd_mux = '0;
        endcase
    end

    // Registered read data, one cycle latency, independent of chipselect
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_soc_system_pio_edge_irq.sv
// Scoreboard bench for soc_system_pio_edge_irq: stimulus pushes expected readdata/irq,
// a negedge monitor pops and compares one cycle after each request.
module tb_soc_system_pio_edge_irq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [7:0]  in_port = '0;
    logic [31:0] readdata;
    logic        irq;

    typedef struct {
        string       name;
        bit          chk_rd;
        logic [31:0] rd;
        bit          chk_irq;
        bit          irq_v;
    } exp_t;

    exp_t exp_q[$];
    logic req_vld = 1'b0;
    logic rsp_vld = 1'b0;
    int   pass_cnt = 0;
    int   chk_cnt = 0;

    soc_system_pio_edge_irq dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic compare(input string name, input string what,
                           input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s %s: got 0x%08h, expected 0x%08h", name, what, act, exp);
    endtask

    // Response valid follows the request by one clock edge
    always @(posedge clk) rsp_vld <= req_vld;

    // Monitor: compare DUT outputs against the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (rsp_vld) begin
            if (exp_q.size() == 0) begin
                chk_cnt++;
                $display("FAIL scoreboard_underflow: got response, expected none");
            end else begin
                e = exp_q.pop_front();
                if (e.chk_rd)  compare(e.name, "readdata", readdata, e.rd);
                if (e.chk_irq) compare(e.name, "irq", 32'(irq), 32'(e.irq_v));
            end
        end
    end

    task automatic step(input string name, input bit do_wr, input logic [2:0] a,
                        input logic [31:0] d, input bit chk_rd, input logic [31:0] exp_rd,
                        input bit chk_irq, input bit exp_irq);
        exp_t e;
        address    = a;
        writedata  = d;
        chipselect = do_wr;
        write_n    = ~do_wr;
        if (chk_rd || chk_irq) begin
            e.name = name; e.chk_rd = chk_rd; e.rd = exp_rd;
            e.chk_irq = chk_irq; e.irq_v = exp_irq;
            exp_q.push_back(e);
            req_vld = 1'b1;
        end
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        req_vld    = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        step("wr", 1'b1, a, d, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) step("idle", 1'b0, 3'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic rd(input string name, input logic [2:0] a, input logic [31:0] e);
        step(name, 1'b0, a, 32'h0, 1'b1, e, 1'b0, 1'b0);
    endtask

    task automatic rdi(input string name, input logic [2:0] a, input logic [31:0] e, input bit ei);
        step(name, 1'b0, a, 32'h0, 1'b1, e, 1'b1, ei);
    endtask

    task automatic irqc(input string name, input bit ei);
        step(name, 1'b0, 3'd0, 32'h0, 1'b0, 32'h0, 1'b1, ei);
    endtask

    task automatic wri(input string name, input logic [2:0] a, input logic [31:0] d, input bit ei);
        step(name, 1'b1, a, d, 1'b0, 32'h0, 1'b1, ei);
    endtask

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state: outputs held at 0 while reset asserted
        @(negedge clk);
        rdi("t1_in_reset", 3'd4, 32'h0, 1'b0);
        reset_n = 1'b1;
        rd("t1_fall_en", 3'd4, 32'hFF);
        rd("t1_rise_en", 3'd1, 32'h0);
        rd("t1_mask",    3'd2, 32'h0);
        rdi("t1_cap",    3'd3, 32'h0, 1'b0);
        rd("t1_data",    3'd0, 32'h0);
        rd("t1_limit",   3'd5, 32'h0);
        rd("t1_unmap6",  3'd6, 32'h0);
        rd("t1_unmap7",  3'd7, 32'h0);

        // Falling edge on bit 0, latency 3 clocks, W1C clears irq next clock
        wr(3'd2, 32'h01);
        in_port = 8'h01;
        idle(5);
        rdi("t2_pre", 3'd3, 32'h0, 1'b0);
        in_port = 8'h00;
        irqc("t2_lat_k0", 1'b0);
        irqc("t2_lat_k1", 1'b0);
        irqc("t2_lat_k2", 1'b0);
        irqc("t2_lat_k3", 1'b1);
        rdi("t2_cap", 3'd3, 32'h01, 1'b1);
        wri("t2_w1c", 3'd3, 32'h01, 1'b0);
        rd("t2_cap_clr", 3'd3, 32'h0);

        // Rising-only select on bit 7, writing 0 to EDGE_CAP does nothing
        wr(3'd1, 32'h80);
        wr(3'd4, 32'h00);
        wr(3'd2, 32'h80);
        in_port = 8'h80;
        idle(5);
        rdi("t3_rise", 3'd3, 32'h80, 1'b1);
        rd("t3_data", 3'd0, 32'h80);
        in_port = 8'h00;
        idle(5);
        rd("t3_no_fall", 3'd3, 32'h80);
        wr(3'd3, 32'h00);
        rdi("t3_w0_keep", 3'd3, 32'h80, 1'b1);
        wri("t3_clr", 3'd3, 32'h80, 1'b0);
        rd("t3_cap_clr", 3'd3, 32'h0);

        // Same-clock W1C and new edge on bit 3: set wins
        wr(3'd1, 32'h08);
        wr(3'd4, 32'h08);
        wr(3'd2, 32'h08);
        in_port = 8'h08;
        idle(5);
        rdi("t5_rise", 3'd3, 32'h08, 1'b1);
        in_port = 8'h00;
        irqc("t5_hold_j0", 1'b1);
        irqc("t5_hold_j1", 1'b1);
        irqc("t5_hold_j2", 1'b1);
        wri("t5_same_clk", 3'd3, 32'h08, 1'b1);
        rdi("t5_cap_kept", 3'd3, 32'h08, 1'b1);
        wri("t5_clr", 3'd3, 32'h08, 1'b0);
        rd("t5_cap_clr", 3'd3, 32'h0);

`ifdef PIO_DEBOUNCE_EN
        // Debounce L=4: 4-cycle pulse rejected, 5-cycle pulse accepted
        wr(3'd5, 32'h4);
        wr(3'd1, 32'h04);
        wr(3'd2, 32'h04);
        rd("t4_limit", 3'd5, 32'h4);
        in_port = 8'h04;
        idle(4);
        in_port = 8'h00;
        for (int i = 0; i < 8; i++) rd("t4_short_data", 3'd0, 32'h0);
        rdi("t4_short_cap", 3'd3, 32'h0, 1'b0);
        in_port = 8'h04;
        idle(5);
        in_port = 8'h00;
        idle(3);
        rd("t4_long_data", 3'd0, 32'h04);
        idle(12);
        rdi("t4_long_cap", 3'd3, 32'h04, 1'b1);
        rd("t4_data_back", 3'd0, 32'h0);
        wri("t4_clr", 3'd3, 32'h04, 1'b0);
`endif

        // Asynchronous reset with everything captured and counters running
        wr(3'd1, 32'hFF);
        wr(3'd2, 32'hFF);
        wr(3'd4, 32'hFF);
        in_port = 8'hFF;
        idle(10);
        rdi("t6_cap_full", 3'd3, 32'hFF, 1'b1);
        in_port = 8'h00;
        idle(2);
        in_port = 8'hFF;
        #1 reset_n = 1'b0;
        #1;
        compare("t6_async", "irq", 32'(irq), 32'h0);
        compare("t6_async", "readdata", readdata, 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        rd("t6_rise_en", 3'd1, 32'h0);
        wr(3'd1, 32'hFF);
        rd("t6_mask", 3'd2, 32'h0);
        rd("t6_fall_en", 3'd4, 32'hFF);
        rd("t6_limit", 3'd5, 32'h0);
        idle(6);
        rdi("t6_rise_after_rst", 3'd3, 32'hFF, 1'b0);
        rd("t6_data", 3'd0, 32'hFF);

        idle(2);
        if (exp_q.size() != 0) begin
            chk_cnt++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
